riscv_alu: RTL and testbench
============================

// Module: riscv_alu
//
// PURPOSE
//   32-bit integer ALU for the EX stage of the pipelined RV32I core.
//   Combinationally computes one of eleven operations on operands a/b selected
//   by a 4-bit alu_control code and flags a zero result.
//   A registered copy of result/zero, one cycle later, feeds the EX/MEM
//   boundary and debug.
//
// PARAMETERS
//   WIDTH   32   datapath width; only 32 is supported (the shift amount is b[4:0])
//
// PORTS
//   clk          input   1      core clock, rising-edge
//   rst          input   1      asynchronous reset, active-high
//   a            input   32     operand A (rs1 or PC)
//   b            input   32     operand B (rs2 or immediate)
//   alu_control  input   4      operation select (see BEHAVIOUR)
//   result       output  32     combinational result
//   zero         output  1      combinational: 1 when result == 32'h0
//   result_q     output  32     result registered on clk
//   zero_q       output  1      zero registered on clk
//
// BEHAVIOUR
//   Clocking and reset (decided): one clock, clk. Reset rst is asynchronous and active-high.
//   Combinational path (zero latency; settles within the same cycle as input changes):
//     0000 ADD   a + b, wraps mod 2^32, carry discarded
//     0001 SUB   a - b, wraps mod 2^32 (implement as a + ~b + 1)
//     0010 AND   a & b
//     0011 OR    a | b
//     0100 XOR   a ^ b
//     0101 SLL   a << b[4:0]
//     0110 SRL   a >> b[4:0], zero fill
//     0111 SRA   a >>> b[4:0], sign fill from a[31]
//     1000 SLT   {31'b0, $signed(a) < $signed(b)}
//     1001 SLTU  {31'b0, a < b} (unsigned)
//     1010 PASSB b (LUI path)
//     1011-1111  result = 32'h0 (reserved); zero = 1 accordingly
//   - zero = (result == 0) for every code, including the reserved ones.
//   - Shift amounts use b[4:0] only; b[31:5] are ignored.
//   - There are no overflow or carry outputs, and no X propagation:
//     a full case with a default.
//   Registered path:
//     - On posedge clk: result_q <= result, zero_q <= zero (1-cycle latency).
//     - While rst = 1 (asynchronous): result_q = 32'h0 and zero_q = 1'b0,
//       immediately and regardless of clk.
//     - On the first posedge after rst falls, the current combinational values are captured.
//     - rst does not affect the combinational result or zero outputs.
//
// STRUCTURE
//   - alu_pkg: localparam opcodes ALU_ADD..ALU_PASSB (4 bits), WIDTH constant.
//     Shared with the decoder/control unit.
//   - Sub-module alu_shifter: 32-bit barrel shifter, 5 log stages, supporting
//     SLL/SRL/SRA. Ports: in, shamt[4:0], dir, arith, out.
//   - The rest is inline: one adder/subtractor shared by ADD, SUB, SLT and SLTU
//     (SLT from sign and overflow, SLTU from borrow), logic ops, a result mux,
//     and an output register.
//
// TESTING
//   - a=20, b=5, codes 0000/0001/0010/0011 -> result 25/15/4/21, zero=0 each;
//     result_q equals each value one clk edge later.
//   - SUB a=b=32'h1234_5678 -> result 0, zero 1.
//     ADD a=32'hFFFF_FFFF, b=1 -> result 0, zero 1 (wrap).
//   - Compare a=32'hFFFF_FFFF, b=1: SLT -> 1, SLTU -> 0.
//     Compare a=0, b=32'h8000_0000: SLT -> 0, SLTU -> 1.
//   - Shifts with a=32'h8000_0010, b=32'hFFFF_FFE4 (shamt 4):
//     SLL -> 32'h0000_0100, SRL -> 32'h0800_0001, SRA -> 32'hF800_0001.
//   - Reserved code 4'b1111 -> result 0, zero 1. XOR 32'hF0F0_F0F0 ^ 32'hFF00_FF00 -> 32'h0FF0_0FF0.
//   - Assert rst between clk edges while result_q=25: result_q -> 0 and
//     zero_q -> 0 without a clock edge; the combinational result stays 25;
//     after release, the next edge captures 25.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcodes and datapath width for the EX-stage ALU.
// The decoder/control unit uses the same constants when it drives alu_control.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

endpackage

// File: rtl/alu_shifter.sv
// 32-bit logarithmic barrel shifter (5 stages) for SLL, SRL and SRA.
// dir = 1 shifts right, dir = 0 shifts left; arith selects sign fill on right shifts.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] in,
    input  logic [4:0]           shamt,
    input  logic                 dir,
    input  logic                 arith,
    output logic [ALU_WIDTH-1:0] out
);

    logic [ALU_WIDTH-1:0] stage [0:5];
    logic                 fill;

    assign fill     = arith & in[ALU_WIDTH-1];
    assign stage[0] = in;

    // Stage k moves the data by 2^k when shamt[k] is set.
    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stage[k+1] = !shamt[k] ? stage[k] :
                            dir       ? {{SH{fill}}, stage[k][ALU_WIDTH-1:SH]} :
                                        {stage[k][ALU_WIDTH-1-SH:0], {SH{1'b0}}};
    end

    assign out = stage[5];

endmodule

// File: rtl/riscv_alu.sv
// RV32I EX-stage ALU: combinational result/zero plus a registered copy
// one cycle later for the EX/MEM boundary and debug.
module riscv_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
);

    logic             do_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             overflow;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [WIDTH-1:0] shift_out;
    logic             shift_right;
    logic             shift_arith;

    // One adder serves ADD, SUB and both compares; subtraction is a + ~b + 1.
    assign do_sub = (alu_control == ALU_SUB) || (alu_control == ALU_SLT) ||
                    (alu_control == ALU_SLTU);
    assign b_op   = do_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, do_sub};

    // Signed less-than is the difference sign corrected by overflow;
    // unsigned less-than is a borrow, i.e. no carry out of a + ~b + 1.
    assign overflow    = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign lt_signed   = sum[WIDTH-1] ^ overflow;
    assign lt_unsigned = ~sum[WIDTH];

    assign shift_right = (alu_control == ALU_SRL) || (alu_control == ALU_SRA);
    assign shift_arith = (alu_control == ALU_SRA);

    alu_shifter u_shifter (
        .in    (a),
        .shamt (b[4:0]),
        .dir   (shift_right),
        .arith (shift_arith),
        .out   (shift_out)
    );

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD, ALU_SUB:           result = sum[WIDTH-1:0];
            ALU_AND:                    result = a & b;
            ALU_OR:                     result = a | b;
            ALU_XOR:                    result = a ^ b;
            ALU_SLL, ALU_SRL, ALU_SRA:  result = shift_out;
            ALU_SLT:                    result = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU:                   result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            ALU_PASSB:                  result = b;
            default:                    result = '0;
        endcase
    end

    assign zero = (result == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result;
            zero_q   <= zero;
        end
    end

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed table, reset corner case,
// and random vectors against an arithmetic reference model.
module tb_riscv_alu;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;

    int vectors_applied;
    int miscompares;

    vec_t vectors[$];

    riscv_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .result      (result),
        .zero        (zero),
        .result_q    (result_q),
        .zero_q      (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour written straight from the operation table.
    function automatic logic [31:0] refResult(input logic [31:0] ra, input logic [31:0] rb,
                                              input logic [3:0] op);
        logic [31:0] r;
        case (op)
            4'd0:    r = ra + rb;
            4'd1:    r = ra - rb;
            4'd2:    r = ra & rb;
            4'd3:    r = ra | rb;
            4'd4:    r = ra ^ rb;
            4'd5:    r = ra << rb[4:0];
            4'd6:    r = ra >> rb[4:0];
            4'd7:    r = $unsigned($signed(ra) >>> rb[4:0]);
            4'd8:    r = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
            4'd9:    r = (ra < rb) ? 32'd1 : 32'd0;
            4'd10:   r = rb;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one operation, checks the combinational outputs mid-cycle and
    // the registered outputs just after the following rising edge.
    task automatic applyStimulus(input string name, input logic [31:0] va, input logic [31:0] vb,
                                 input logic [3:0] op, input logic [31:0] exp_r,
                                 input logic exp_z);
        @(negedge clk);
        a           = va;
        b           = vb;
        alu_control = op;
        #1;
        checkOutput({name, " result"}, result, exp_r);
        checkOutput({name, " zero"}, {31'b0, zero}, {31'b0, exp_z});
        @(posedge clk);
        #1;
        checkOutput({name, " result_q"}, result_q, exp_r);
        checkOutput({name, " zero_q"}, {31'b0, zero_q}, {31'b0, exp_z});
    endtask

    initial begin
        logic [31:0] ra, rb, rr;
        logic [3:0]  rop;

        vectors_applied = 0;
        miscompares     = 0;
        rst         = 1'b1;
        a           = 32'd0;
        b           = 32'd0;
        alu_control = 4'd0;

        vectors.push_back('{32'd20, 32'd5, 4'b0000, 32'd25, 1'b0});
        vectors.push_back('{32'd20, 32'd5, 4'b0001, 32'd15, 1'b0});
        vectors.push_back('{32'd20, 32'd5, 4'b0010, 32'd4,  1'b0});
        vectors.push_back('{32'd20, 32'd5, 4'b0011, 32'd21, 1'b0});
        vectors.push_back('{32'h1234_5678, 32'h1234_5678, 4'b0001, 32'd0, 1'b1});
        vectors.push_back('{32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 1'b1});
        vectors.push_back('{32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd1, 1'b0});
        vectors.push_back('{32'hFFFF_FFFF, 32'd1, 4'b1001, 32'd0, 1'b1});
        vectors.push_back('{32'd0, 32'h8000_0000, 4'b1000, 32'd0, 1'b1});
        vectors.push_back('{32'd0, 32'h8000_0000, 4'b1001, 32'd1, 1'b0});
        vectors.push_back('{32'h8000_0010, 32'hFFFF_FFE4, 4'b0101, 32'h0000_0100, 1'b0});
        vectors.push_back('{32'h8000_0010, 32'hFFFF_FFE4, 4'b0110, 32'h0800_0001, 1'b0});
        vectors.push_back('{32'h8000_0010, 32'hFFFF_FFE4, 4'b0111, 32'hF800_0001, 1'b0});
        vectors.push_back('{32'hDEAD_BEEF, 32'h1234_5678, 4'b1111, 32'd0, 1'b1});
        vectors.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 32'h0FF0_0FF0, 1'b0});
        vectors.push_back('{32'h1111_1111, 32'hCAFE_0000, 4'b1010, 32'hCAFE_0000, 1'b0});
        vectors.push_back('{32'h8000_0000, 32'h0000_001F, 4'b0111, 32'hFFFF_FFFF, 1'b0});
        vectors.push_back('{32'h8000_0000, 32'h0000_0020, 4'b0110, 32'h8000_0000, 1'b0});
        vectors.push_back('{32'h0000_0001, 32'h0000_001F, 4'b0101, 32'h8000_0000, 1'b0});
        vectors.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 4'b1000, 32'd0, 1'b1});
        vectors.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 4'b1000, 32'd1, 1'b0});
        vectors.push_back('{32'hABCD_0000, 32'h0000_1234, 4'b1011, 32'd0, 1'b1});

        // Registered outputs must be cleared while reset is held.
        #2;
        checkOutput("reset result_q", result_q, 32'd0);
        checkOutput("reset zero_q", {31'b0, zero_q}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vectors[i])
            applyStimulus($sformatf("vec%0d", i), vectors[i].a, vectors[i].b, vectors[i].op,
                          vectors[i].exp_result, vectors[i].exp_zero);

        // Asynchronous reset between edges, then recapture on the next edge.
        applyStimulus("pre-reset add", 32'd20, 32'd5, 4'b0000, 32'd25, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst result_q", result_q, 32'd0);
        checkOutput("async rst zero_q", {31'b0, zero_q}, 32'd0);
        checkOutput("async rst comb result", result, 32'd25);
        @(negedge clk);
        checkOutput("held rst result_q", result_q, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset result_q", result_q, 32'd25);
        checkOutput("post-reset zero_q", {31'b0, zero_q}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 4'($urandom_range(0, 15));
            if (i % 8 == 0) rb = ra;
            if (i % 16 == 1) ra = 32'h8000_0000;
            rr = refResult(ra, rb, rop);
            applyStimulus($sformatf("rand%0d op%0d", i, rop), ra, rb, rop, rr, rr == 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
